// File: rtl/ahb_sub_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the AHB5 memory subordinate.
package ahb_sub_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Lanes covered by a transfer of 2^size bytes at the given in-word offset (buses up to 64 bits).
  function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [2:0] size);
    logic [15:0] ones;
    logic [15:0] shifted;
    ones    = (16'd1 << (16'd1 << size)) - 16'd1;
    shifted = ones << offset;
    return shifted[7:0];
  endfunction

  function automatic logic is_aligned(input logic [2:0] offset, input logic [2:0] size);
    logic [7:0] full;
    full = (8'd1 << size) - 8'd1;
    return (offset & full[2:0]) == 3'b000;
  endfunction

endpackage

// File: rtl/ahb_sub_excl_mon.sv
// Single-entry exclusive-access monitor: one reservation (master, word) set by
// exclusive reads and consumed by a matching exclusive write or any committed write to that word.
module ahb_sub_excl_mon #(
  parameter int HMASTER_WIDTH = 4,
  parameter int WADDR_WIDTH   = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     evValid_i,
  input  logic                     evWrite_i,
  input  logic                     evExcl_i,
  input  logic [HMASTER_WIDTH-1:0] evMaster_i,
  input  logic [WADDR_WIDTH-1:0]   evWord_i,
  output logic                     pass_o
);

  logic                     valid_q;
  logic [HMASTER_WIDTH-1:0] master_q;
  logic [WADDR_WIDTH-1:0]   word_q;
  logic                     match;
  logic                     load;
  logic                     clear;

  assign match  = valid_q && (master_q == evMaster_i) && (word_q == evWord_i);
  assign pass_o = evValid_i && evExcl_i && (!evWrite_i || match);
  assign load   = evValid_i && evExcl_i && !evWrite_i;
  // A failed exclusive write commits nothing, so it must not disturb the reservation.
  assign clear  = evValid_i && evWrite_i && valid_q && (word_q == evWord_i)
                  && (!evExcl_i || match);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      master_q <= '0;
      word_q   <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      master_q <= evMaster_i;
      word_q   <= evWord_i;
    end else if (clear) begin
      valid_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_sub_mem.sv
// AHB5 subordinate backed by a byte-addressable array, with programmable wait
// states, two-cycle ERROR response, write strobes and an exclusive monitor.
module ahb_sub_mem
  import ahb_sub_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int HMASTER_WIDTH = 4,
  parameter int MEM_BYTES     = 4096,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     hclk,
  input  logic                     hreset_n,
  input  logic                     hsel,
  input  logic [ADDR_WIDTH-1:0]    haddr,
  input  logic [1:0]               htrans,
  input  logic                     hwrite,
  input  logic [2:0]               hsize,
  input  logic [2:0]               hburst,
  input  logic                     hexcl,
  input  logic [HMASTER_WIDTH-1:0] hmaster,
  input  logic [DATA_WIDTH-1:0]    hwdata,
  input  logic [DATA_WIDTH/8-1:0]  hwstrb,
  input  logic                     hready,
  output logic [DATA_WIDTH-1:0]    hrdata,
  output logic                     hreadyout,
  output logic                     hresp,
  output logic                     hexokay
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_BYTES);
  localparam int WADR_W = IDX_W - OFF_W;
  localparam int WORDS  = MEM_BYTES / BYTES;

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     hreadyout_q;
  logic                     hresp_q;
  logic                     pend_q;
  logic                     wr_q;
  logic                     excl_q;
  logic [2:0]               size_q;
  logic [2:0]               off_q;
  logic [WADR_W-1:0]        wordAddr_q;
  logic [HMASTER_WIDTH-1:0] master_q;
  logic [DATA_WIDTH-1:0]    mem_q [WORDS];

  logic [2:0]       addrOff;
  logic             accErr;
  logic             accept;
  logic             complete;
  logic             exclPass;
  logic             wrEn;
  logic [7:0]       maskFull;
  logic [BYTES-1:0] wrLanes;
  logic             unusedBits;

  assign addrOff  = 3'(haddr[OFF_W-1:0]);
  assign accErr   = (haddr >= ADDR_WIDTH'(MEM_BYTES)) || (hsize > 3'(OFF_W))
                    || !is_aligned(addrOff, hsize);
  assign accept   = hsel && hready && htrans[1]
                    && ((state_q == ST_IDLE) || (state_q == ST_ERR2));
  assign complete = pend_q && hreadyout_q;

  // IDLE and ERR2 both sample new address phases; WAIT and ERR1 hold the bus.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      excl_q      <= 1'b0;
      size_q      <= 3'd0;
      off_q       <= 3'd0;
      wordAddr_q  <= '0;
      master_q    <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          pend_q      <= 1'b0;
          if (accept) begin
            if (accErr) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else begin
              pend_q     <= 1'b1;
              wr_q       <= hwrite;
              excl_q     <= hexcl;
              size_q     <= hsize;
              off_q      <= addrOff;
              wordAddr_q <= haddr[IDX_W-1:OFF_W];
              master_q   <= hmaster;
              if (WAIT_STATES > 0) begin
                state_q     <= ST_WAIT;
                hreadyout_q <= 1'b0;
                cnt_q       <= 4'(WAIT_STATES - 1);
              end
            end
          end
        end
      endcase
    end
  end

  ahb_sub_excl_mon #(
    .HMASTER_WIDTH(HMASTER_WIDTH),
    .WADDR_WIDTH  (WADR_W)
  ) u_excl_mon (
    .clk_i     (hclk),
    .rst_ni    (hreset_n),
    .evValid_i (complete),
    .evWrite_i (wr_q),
    .evExcl_i  (excl_q),
    .evMaster_i(master_q),
    .evWord_i  (wordAddr_q),
    .pass_o    (exclPass)
  );

  assign maskFull = lane_mask(off_q, size_q);
  assign wrLanes  = hwstrb & BYTES'(maskFull);
  assign wrEn     = complete && wr_q && (!excl_q || exclPass);

  // Array contents survive reset; only the lanes both strobed and addressed change.
  always_ff @(posedge hclk) begin
    if (wrEn) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wrLanes[i]) mem_q[wordAddr_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hrdata     = (complete && !wr_q) ? mem_q[wordAddr_q] : '0;
  assign hreadyout  = hreadyout_q;
  assign hresp      = hresp_q;
  assign hexokay    = exclPass;
  assign unusedBits = ^{hburst, htrans[0]};

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Self-checking bench: two subordinates (0 and 3 wait states) driven by directed
// and randomized transfers, compared against a byte-level behavioural model.
module tb_ahb_sub_mem;

  logic        clk;
  logic        hreset_n;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hexcl;
  logic [3:0]  hmaster;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;
  logic        hexokay0, hexokay1;

  bit          cur;
  logic        curReady, curResp, curExok;
  logic [31:0] curRdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] refMem   [2][4096];
  bit         refKnown [2][4096];
  bit         refValid [2];
  int         refMaster[2];
  int         refWord  [2];

  ahb_sub_mem #(.WAIT_STATES(0)) dut0 (
    .hclk(clk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hexcl(hexcl), .hmaster(hmaster),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready), .hrdata(hrdata0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hexokay(hexokay0)
  );

  ahb_sub_mem #(.WAIT_STATES(3)) dut1 (
    .hclk(clk), .hreset_n(hreset_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hexcl(hexcl), .hmaster(hmaster),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready), .hrdata(hrdata1),
    .hreadyout(hreadyout1), .hresp(hresp1), .hexokay(hexokay1)
  );

  assign curReady = cur ? hreadyout1 : hreadyout0;
  assign curResp  = cur ? hresp1     : hresp0;
  assign curExok  = cur ? hexokay1   : hexokay0;
  assign curRdata = cur ? hrdata1    : hrdata0;
  assign hready   = curReady;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic busIdle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hexcl  = 1'b0;
  endtask

  task automatic applyStimulus(input int t, input bit wr, input logic [31:0] addr,
                               input logic [2:0] size, input bit excl, input int mst);
    cur     = (t == 1);
    hsel0   = (t == 0);
    hsel1   = (t == 1);
    htrans  = 2'b10;
    hwrite  = wr;
    haddr   = addr;
    hsize   = size;
    hburst  = 3'b000;
    hexcl   = excl;
    hmaster = 4'(mst);
  endtask

  // Behavioural model of one transfer, derived from the addressing and exclusive rules.
  task automatic modelXfer(input int t, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input bit excl, input int mst,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           output bit err, output bit exok, output logic [31:0] rdata,
                           output bit known);
    int base, off, nbytes;
    bit doWrite;
    err   = (addr >= 32'd4096) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    exok  = 1'b0;
    rdata = 32'h0;
    known = 1'b1;
    if (err) return;
    off    = int'(addr % 32'd4);
    base   = int'(addr) - off;
    nbytes = 1 << size;
    if (!wr) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] = refMem[t][base+i];
        if (!refKnown[t][base+i]) known = 1'b0;
      end
      if (excl) begin
        exok         = 1'b1;
        refValid[t]  = 1'b1;
        refMaster[t] = mst;
        refWord[t]   = base / 4;
      end
    end else begin
      doWrite = 1'b1;
      if (excl) begin
        exok    = refValid[t] && (refMaster[t] == mst) && (refWord[t] == base / 4);
        doWrite = exok;
        if (exok) refValid[t] = 1'b0;
      end else if (refValid[t] && refWord[t] == base / 4) begin
        refValid[t] = 1'b0;
      end
      if (doWrite) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i] && i >= off && i < off + nbytes) begin
            refMem[t][base+i]   = wdata[8*i +: 8];
            refKnown[t][base+i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic waitDone(output int nWait, output bit lowResp);
    nWait   = 0;
    lowResp = 1'b0;
    while (curReady !== 1'b1 && nWait < 64) begin
      if (curResp === 1'b1) lowResp = 1'b1;
      nWait++;
      @(negedge clk);
    end
  endtask

  task automatic checkDataPhase(input string tag, input int t, input bit err, input bit exok,
                                input bit wr, input logic [31:0] rdata, input bit known);
    int  nWait;
    bit  lowResp;
    waitDone(nWait, lowResp);
    checkOutput({tag, ".waits"}, nWait, err ? 1 : (t == 1 ? 3 : 0));
    checkOutput({tag, ".lowresp"}, 32'(lowResp), 32'(err));
    checkOutput({tag, ".resp"}, 32'(curResp), 32'(err));
    checkOutput({tag, ".exokay"}, 32'(curExok), 32'(exok));
    if (wr || err) checkOutput({tag, ".rdata0"}, curRdata, 32'h0);
    else if (known) checkOutput({tag, ".rdata"}, curRdata, rdata);
  endtask

  task automatic runXfer(input int t, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input bit excl, input int mst,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input string tag, output logic [31:0] obsData);
    bit err, exok, known;
    logic [31:0] rdata;
    @(negedge clk);
    applyStimulus(t, wr, addr, size, excl, mst);
    modelXfer(t, wr, addr, size, excl, mst, wdata, wstrb, err, exok, rdata, known);
    @(negedge clk);
    busIdle();
    hwdata = wdata;
    hwstrb = wstrb;
    checkDataPhase(tag, t, err, exok, wr, rdata, known);
    obsData = curRdata;
  endtask

  initial begin
    logic [31:0] obs;
    bit          err, exok, known;
    logic [31:0] rdata;
    int          nWait;
    bit          lowResp;

    clk      = 1'b0;
    hreset_n = 1'b0;
    cur      = 1'b0;
    haddr    = 32'h0;
    hsize    = 3'd0;
    hburst   = 3'd0;
    hmaster  = 4'd0;
    hwdata   = 32'h0;
    hwstrb   = 4'h0;
    busIdle();
    refValid[0] = 1'b0;
    refValid[1] = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst.ready0", 32'(hreadyout0), 32'd1);
    checkOutput("rst.resp0",  32'(hresp0),     32'd0);
    checkOutput("rst.exok0",  32'(hexokay0),   32'd0);
    checkOutput("rst.rdata0", hrdata0,         32'h0);
    checkOutput("rst.ready1", 32'(hreadyout1), 32'd1);
    checkOutput("rst.rdata1", hrdata1,         32'h0);
    hreset_n = 1'b1;

    // Zero-wait read, write and read-back.
    runXfer(0, 0, 32'h10, 3'd2, 0, 0, 32'h0, 4'h0, "zw.rd", obs);
    runXfer(0, 1, 32'h10, 3'd2, 0, 0, 32'hDEADBEEF, 4'hF, "zw.wr", obs);
    runXfer(0, 0, 32'h10, 3'd2, 0, 0, 32'h0, 4'h0, "zw.rdback", obs);
    checkOutput("zw.const", obs, 32'hDEADBEEF);

    // IDLE/BUSY with hsel: no wait and no response.
    @(negedge clk);
    cur = 1'b0; hsel0 = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h10;
    @(negedge clk);
    checkOutput("busy.ready", 32'(hreadyout0), 32'd1);
    checkOutput("busy.resp",  32'(hresp0),     32'd0);
    busIdle();

    // Three wait states, write then back-to-back read with no bubble.
    @(negedge clk);
    applyStimulus(1, 1, 32'h4, 3'd2, 0, 0);
    modelXfer(1, 1, 32'h4, 3'd2, 0, 0, 32'h00000004, 4'hF, err, exok, rdata, known);
    @(negedge clk);
    busIdle();
    hwdata = 32'h00000004;
    hwstrb = 4'hF;
    waitDone(nWait, lowResp);
    checkOutput("b2b.wr.waits", nWait, 3);
    checkOutput("b2b.wr.lowresp", 32'(lowResp), 32'd0);
    applyStimulus(1, 0, 32'h4, 3'd2, 0, 0);
    modelXfer(1, 0, 32'h4, 3'd2, 0, 0, 32'h0, 4'h0, err, exok, rdata, known);
    @(negedge clk);
    busIdle();
    checkDataPhase("b2b.rd", 1, err, exok, 1'b0, rdata, known);
    checkOutput("b2b.const", curRdata, 32'h00000004);

    // Halfword write merges into an existing word.
    runXfer(0, 1, 32'h20, 3'd2, 0, 0, 32'h11223344, 4'hF, "hw.wr", obs);
    runXfer(0, 1, 32'h22, 3'd1, 0, 0, 32'hAAAAAAAA, 4'hF, "hw.wrh", obs);
    runXfer(0, 0, 32'h20, 3'd2, 0, 0, 32'h0, 4'h0, "hw.rd", obs);
    checkOutput("hw.const", obs, 32'hAAAA3344);

    // Error responses: out of range, misaligned, errored write.
    runXfer(0, 0, 32'h1000, 3'd2, 0, 0, 32'h0, 4'h0, "err.range", obs);
    runXfer(0, 0, 32'h02,   3'd2, 0, 0, 32'h0, 4'h0, "err.align", obs);
    runXfer(0, 1, 32'h22,   3'd2, 0, 0, 32'h55555555, 4'hF, "err.wr", obs);
    runXfer(0, 1, 32'h20,   3'd3, 0, 0, 32'h55555555, 4'hF, "err.size", obs);
    runXfer(0, 0, 32'h20,   3'd2, 0, 0, 32'h0, 4'h0, "err.rdback", obs);
    checkOutput("err.const", obs, 32'hAAAA3344);

    // Exclusive pass, then failure after an intervening write by another master.
    runXfer(0, 1, 32'h40, 3'd2, 0, 2, 32'h01010101, 4'hF, "ex.init", obs);
    runXfer(0, 0, 32'h40, 3'd2, 1, 2, 32'h0, 4'h0, "ex.rd1", obs);
    runXfer(0, 1, 32'h40, 3'd2, 1, 2, 32'hCAFEF00D, 4'hF, "ex.wr1", obs);
    runXfer(0, 0, 32'h40, 3'd2, 0, 2, 32'h0, 4'h0, "ex.chk1", obs);
    checkOutput("ex.const1", obs, 32'hCAFEF00D);
    runXfer(0, 0, 32'h40, 3'd2, 1, 2, 32'h0, 4'h0, "ex.rd2", obs);
    runXfer(0, 1, 32'h40, 3'd2, 0, 5, 32'h12345678, 4'hF, "ex.other", obs);
    runXfer(0, 1, 32'h40, 3'd2, 1, 2, 32'h0BADBEEF, 4'hF, "ex.wr2", obs);
    runXfer(0, 0, 32'h40, 3'd2, 0, 2, 32'h0, 4'h0, "ex.chk2", obs);
    checkOutput("ex.const2", obs, 32'h12345678);

    // Reset during a wait state abandons the write.
    runXfer(1, 1, 32'h8, 3'd2, 0, 0, 32'h77777777, 4'hF, "rw.init", obs);
    @(negedge clk);
    applyStimulus(1, 1, 32'h8, 3'd2, 0, 0);
    @(negedge clk);
    busIdle();
    hwdata = 32'h99999999;
    hwstrb = 4'hF;
    checkOutput("rw.inwait", 32'(hreadyout1), 32'd0);
    #2 hreset_n = 1'b0;
    #1;
    checkOutput("rw.ready", 32'(hreadyout1), 32'd1);
    checkOutput("rw.resp",  32'(hresp1),     32'd0);
    checkOutput("rw.exok",  32'(hexokay1),   32'd0);
    checkOutput("rw.rdata", hrdata1,         32'h0);
    refValid[0] = 1'b0;
    refValid[1] = 1'b0;
    @(negedge clk);
    hreset_n = 1'b1;
    runXfer(1, 0, 32'h8, 3'd2, 0, 0, 32'h0, 4'h0, "rw.rdback", obs);
    checkOutput("rw.const", obs, 32'h77777777);

    // Randomized traffic over a small region so exclusive reservations collide.
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 4; w++)
        runXfer(t, 1, 32'h100 + 32'(4*w), 3'd2, 0, 0, $urandom, 4'hF, "rnd.init", obs);
      for (int n = 0; n < 30; n++) begin
        int          r;
        logic [2:0]  sz;
        logic [31:0] a;
        r  = int'($urandom_range(0, 7));
        sz = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'd3;
        a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                         : 32'h100 + 32'($urandom_range(0, 15));
        runXfer(t, 1'($urandom_range(0, 1)), a, sz, ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)),
                $sformatf("rnd%0d.%0d", t, n), obs);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sub_mem.md
Name: ahb_sub_mem

Overview:
- Synthesizable AHB5 subordinate (responder) with a byte-addressable memory array.
- Sits at the subordinate end of the bus, behind a decoder/multiplexor.
- Serves as the RTL target/DUT stand-in for manager-side agent testing.
- Supports programmable wait states, ERROR two-cycle response, write strobes, and a single-entry exclusive-access monitor.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width (32 or 64)
HMASTER_WIDTH, 4, hmaster width
MEM_BYTES, 4096, array size in bytes (power of two, multiple of DATA_WIDTH/8)
WAIT_STATES, 0, wait cycles inserted before every OKAY data phase (0..15)

Ports:
hclk  in  1  bus clock
hreset_n  in  1  asynchronous active-low reset
hsel  in  1  decoder select
haddr  in  ADDR_WIDTH  address
htrans  in  2  IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
hwrite  in  1  1=write
hsize  in  3  transfer size, log2 bytes
hburst  in  3  burst type (accepted; not checked)
hexcl  in  1  exclusive transfer
hmaster  in  HMASTER_WIDTH  manager ID
hwdata  in  DATA_WIDTH  write data (data phase)
hwstrb  in  DATA_WIDTH/8  write strobes (data phase)
hready  in  1  bus-level ready from multiplexor
hrdata  out  DATA_WIDTH  read data
hreadyout  out  1  subordinate ready
hresp  out  1  0=OKAY 1=ERROR
hexokay  out  1  exclusive okay

Behaviour:
- Reset (hreset_n low, async): hreadyout=1, hresp=0, hexokay=0, hrdata=0, FSM=IDLE, wait counter=0, monitor invalid. Array contents are not reset. Reset mid-transfer abandons it; no array write occurs.
- Address phase accepted at rising edge when hsel & hready & htrans[1]. IDLE/BUSY, or hsel=0, gives a zero-wait OKAY data phase with no side effects. Nothing is sampled while hready=0.
- Error check at acceptance:
  - haddr >= MEM_BYTES, or
  - hsize > log2(DATA_WIDTH/8), or
  - haddr not aligned to 2^hsize.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: on accepted error -> ERR1; on accepted good transfer -> WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else stay IDLE with hreadyout=1 next cycle.
  - WAIT: hreadyout=0, hresp=0; counter decrements; at 0 -> DATA (completion cycle, hreadyout=1).
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE, or directly accept the new address phase sampled this edge.
- A transfer presented during ERR1 is ignored. A new address phase in the completion cycle is pipelined (back-to-back, no bubble).
- Writes:
  - Commit at the completion edge.
  - Byte lane i is written iff hwstrb[i] & lane_mask[i], where lane_mask comes from haddr low bits and hsize.
  - Errored writes never modify the array.
- Reads:
  - hrdata is the full aligned word at the registered address, driven only in the completion cycle; 0 otherwise.
  - A read immediately after a write to the same word returns the new data.
- Exclusive monitor (one entry: valid, master, word address):
  - Exclusive read OKAY: loads the entry; hexokay=1 in the completion cycle.
  - Exclusive write: if the entry matches valid, master and word, the write commits, hexokay=1 and the entry clears. Otherwise the write is suppressed, hexokay=0 and hresp stays OKAY.
  - Any committed non-exclusive write to the monitored word clears the entry.
  - Same-edge load and clear: the load wins.
  - hexokay=0 on ERROR and on non-exclusive transfers.
- Address width: only log2(MEM_BYTES) bits index the array. Upper bits are used only for the range check.

Decomposition:
- ahb_sub_pkg holds:
  - htrans and hresp encodings
  - FSM state enum
  - lane-mask function (addr, size -> strobe mask)
  - alignment-check function
- Sub-module ahb_sub_excl_mon holds the monitor storage plus match/load/clear logic, with a single pass/fail output.

Test Plan:
- Reset, then read 0x10 with WAIT_STATES=0 -> hreadyout stays 1, hresp=0. Then write 0xDEADBEEF, hwstrb=0xF, read back -> 0xDEADBEEF one cycle after the address phase.
- WAIT_STATES=3, write 0x00000004 then back-to-back read same address -> 3 cycles of hreadyout=0 each; read returns the written data; no bubble between transfers.
- Write 0x11223344 to 0x20, then a halfword write 0xAAAA at 0x22 (hsize=1, hwstrb=0xF) -> read 0x20 returns 0xAAAA3344.
- Read 0x1000 (MEM_BYTES=4096), and a word read at 0x02 -> each gives hreadyout 0 then 1 with hresp=1 both cycles; errored write leaves the array unchanged.
- Exclusive read 0x40 by hmaster=2, exclusive write 0x40 by master 2 -> hexokay=1, data written. Repeat with an intervening normal write by master 5 -> hexokay=0, data not written, hresp=0.
- Assert hreset_n low during a WAIT cycle of a write -> outputs return to reset values asynchronously; the target location keeps its old value.
